systolic_tile_sequencer: RTL
============================

SYSTOLIC_TILE_SEQUENCER -- requirements
Module: systolic_tile_sequencer

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 16: array rows/cols; also the number of OFM rows drained per tile.
REQ-002 SHALL have parameter BUFFER_SIZE, default 27: words per IFM/weight buffer, i.e. reduction depth per tile.
REQ-003 SHALL have parameter TILE_WIDTH, default 8: width of the tile count.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; sampled only in IDLE.
REQ-007 num_tiles  in  TILE_WIDTH  tile count; latched when start is accepted.
REQ-008 ofm_ready  in  1  OFM memory can accept a write this cycle.
REQ-009 buf_load_en  out  1  IFM and weight buffer load strobe.
REQ-010 buf_addr  out  clog2(BUFFER_SIZE)  buffer word index.
REQ-011 shift_en  out  1  advance the systolic array and skewed feeders one step.
REQ-012 feed_idx  out  clog2(BUFFER_SIZE+2*SYSTOLIC_SIZE-2)  compute step index.
REQ-013 ofm_we  out  1  OFM write strobe.
REQ-014 ofm_addr  out  TILE_WIDTH+clog2(SYSTOLIC_SIZE)  OFM row address.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when the last tile has drained.

Function
REQ-017 SHALL implement the states IDLE, LOAD, COMPUTE, DRAIN and DONE.
REQ-018 IDLE with start=1: latch num_tiles, clear the tile counter, go to LOAD; if the latched num_tiles=0, go to DONE instead.
REQ-019 LOAD: BUFFER_SIZE cycles (27 at default); buf_load_en=1; buf_addr = 0..BUFFER_SIZE-1, one per cycle; then COMPUTE.
REQ-020 COMPUTE: C = BUFFER_SIZE+2*SYSTOLIC_SIZE-2 cycles (57 at default); shift_en=1; feed_idx = 0..C-1; then DRAIN.
REQ-021 DRAIN: row counter r runs 0..SYSTOLIC_SIZE-1.
REQ-022 In DRAIN, ofm_we = ofm_ready, combinational from the current state.
REQ-023 In DRAIN, ofm_addr = tile*SYSTOLIC_SIZE + r.
REQ-024 In DRAIN, r advances only on cycles where ofm_we=1; while ofm_ready=0, r and ofm_addr hold.
REQ-025 After the write of r=SYSTOLIC_SIZE-1: if tile<num_tiles-1, increment tile and go to LOAD, else go to DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 start while busy=1 SHALL be ignored, and the latched num_tiles SHALL NOT change.
REQ-028 start held high through DONE SHALL launch a new run on the first IDLE cycle.
REQ-029 Outside their own phase, buf_load_en, shift_en and ofm_we SHALL be 0.
REQ-030 Outside their own phase, buf_addr, feed_idx and ofm_addr SHALL be 0.
REQ-031 At most one of buf_load_en, shift_en, ofm_we SHALL be high in any cycle.
REQ-032 Counters SHALL never exceed their terminal values; there is no wrap-around within a phase.
REQ-033 num_tiles=2^TILE_WIDTH-1 SHALL complete with ofm_addr reaching (2^TILE_WIDTH-1)*SYSTOLIC_SIZE-1 without overflow.
REQ-034 Phase transitions SHALL insert no idle cycles.
REQ-035 Total latency for N tiles with ofm_ready=1 throughout = 1 + N*(BUFFER_SIZE+C+SYSTOLIC_SIZE) cycles from start accept to done.

Reset
REQ-036 rst=1 SHALL force IDLE and clear all counters, the latched num_tiles and all outputs to 0 on the next edge, from any state.
REQ-037 The first cycle after rst deasserts SHALL be IDLE, with start sampled normally.

Structure
REQ-038 A shared package SHALL hold the state enum, the default SYSTOLIC_SIZE/BUFFER_SIZE, the COMPUTE_CYCLES expression and the address-width functions.
REQ-039 A single sub-module tile_phase_counter (load, enable, terminal count, last flag) SHALL be instantiated for the phase counter.
REQ-040 The FSM, the tile counter and the output decode SHALL stay in the top module.

Verification
REQ-041 num_tiles=1, start pulsed one cycle, ofm_ready=1 -> buf_load_en 27 cycles, shift_en 57, ofm_we 16 with ofm_addr 0..15, done 101 cycles after start accept.
REQ-042 num_tiles=3 -> 48 writes with ofm_addr 0..47 in order, three LOAD phases, a single done pulse.
REQ-043 ofm_ready=0 for 5 cycles while r=7 -> ofm_addr holds at 7, no write, then resumes at 7; done delayed by exactly 5 cycles.
REQ-044 rst asserted at feed_idx=30 -> next cycle IDLE, all outputs 0; a new start runs a full, correct tile.
REQ-045 start toggled and num_tiles changed during COMPUTE -> no effect; num_tiles=0 accepted in IDLE -> done the next cycle, with no load, shift or write.

Source files
------------

// File: rtl/systolic_tile_sequencer_pkg.sv
// Shared types, default geometry and width helpers for the systolic tile sequencer.
package systolic_tile_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int unsigned DEF_SYSTOLIC_SIZE = 16;
  localparam int unsigned DEF_BUFFER_SIZE   = 27;

  // Reduction depth plus the fill and flush of the skewed feeders.
  function automatic int unsigned compute_cycles(input int unsigned buffer_size,
                                                 input int unsigned systolic_size);
    return buffer_size + 2 * systolic_size - 2;
  endfunction

  localparam int unsigned DEF_COMPUTE_CYCLES = compute_cycles(DEF_BUFFER_SIZE, DEF_SYSTOLIC_SIZE);

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/systolic_tile_sequencer_phase_counter.sv
// Shared phase counter: clears on load, wraps to zero when enabled at its terminal count.
module tile_phase_counter
  import systolic_tile_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  logic [WIDTH-1:0] count_q, count_d;

  assign last  = (count_q == term);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer: per tile, load the buffers, run the systolic compute, then drain OFM rows.
module systolic_tile_sequencer
  import systolic_tile_sequencer_pkg::*;
#(
  parameter int unsigned SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
  parameter int unsigned BUFFER_SIZE   = DEF_BUFFER_SIZE,
  parameter int unsigned TILE_WIDTH    = 8
) (
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic                                                        start,
  input  logic [TILE_WIDTH-1:0]                                       num_tiles,
  input  logic                                                        ofm_ready,
  output logic                                                        buf_load_en,
  output logic [addr_width(BUFFER_SIZE)-1:0]                          buf_addr,
  output logic                                                        shift_en,
  output logic [addr_width(compute_cycles(BUFFER_SIZE, SYSTOLIC_SIZE))-1:0] feed_idx,
  output logic                                                        ofm_we,
  output logic [TILE_WIDTH+addr_width(SYSTOLIC_SIZE)-1:0]             ofm_addr,
  output logic                                                        busy,
  output logic                                                        done
);

  localparam int unsigned C      = compute_cycles(BUFFER_SIZE, SYSTOLIC_SIZE);
  localparam int unsigned BA_W   = addr_width(BUFFER_SIZE);
  localparam int unsigned FI_W   = addr_width(C);
  localparam int unsigned R_W    = addr_width(SYSTOLIC_SIZE);
  localparam int unsigned OA_W   = TILE_WIDTH + R_W;
  localparam int unsigned MAX1_W = (FI_W > BA_W) ? FI_W : BA_W;
  localparam int unsigned CNT_W  = (MAX1_W > R_W) ? MAX1_W : R_W;

  state_e                state_q, state_d;
  logic [TILE_WIDTH-1:0] tile_q, tile_d;
  logic [TILE_WIDTH-1:0] num_tiles_q, num_tiles_d;
  logic [CNT_W-1:0]      cnt, term;
  logic                  cnt_last, cnt_load, cnt_en, tile_last;

  // One counter serves all three phases; the terminal value follows the state.
  always_comb begin
    case (state_q)
      ST_LOAD:    term = CNT_W'(BUFFER_SIZE - 1);
      ST_COMPUTE: term = CNT_W'(C - 1);
      ST_DRAIN:   term = CNT_W'(SYSTOLIC_SIZE - 1);
      default:    term = '0;
    endcase
  end

  assign cnt_load  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign cnt_en    = (state_q == ST_LOAD) || (state_q == ST_COMPUTE) ||
                     ((state_q == ST_DRAIN) && ofm_ready);
  assign tile_last = (tile_q == num_tiles_q - TILE_WIDTH'(1));

  tile_phase_counter #(.WIDTH(CNT_W)) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .term  (term),
    .count (cnt),
    .last  (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    tile_d      = tile_q;
    num_tiles_d = num_tiles_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_tiles_d = num_tiles;
          tile_d      = '0;
          state_d     = (num_tiles == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD:    if (cnt_last) state_d = ST_COMPUTE;
      ST_COMPUTE: if (cnt_last) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (ofm_ready && cnt_last) begin
          if (tile_last) begin
            state_d = ST_DONE;
          end else begin
            tile_d  = tile_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tile_q      <= '0;
      num_tiles_q <= '0;
    end else begin
      state_q     <= state_d;
      tile_q      <= tile_d;
      num_tiles_q <= num_tiles_d;
    end
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    buf_load_en = (state_q == ST_LOAD);
    shift_en    = (state_q == ST_COMPUTE);
    ofm_we      = (state_q == ST_DRAIN) && ofm_ready;
    buf_addr    = buf_load_en ? cnt[BA_W-1:0] : '0;
    feed_idx    = shift_en ? cnt[FI_W-1:0] : '0;
    ofm_addr    = '0;
    if (state_q == ST_DRAIN) begin
      ofm_addr = OA_W'(tile_q) * OA_W'(SYSTOLIC_SIZE) + OA_W'(cnt[R_W-1:0]);
    end
  end

endmodule
